// File: rtl/rr_vc_scheduler.sv
// rr_vc_scheduler: work-conserving round-robin scheduler moving words from
// 4 input VC FIFOs to 4 output FIFOs. Each cycle it grants at most one non-empty
// source whose destination (2 MSBs of its head word) is not almost-full. The grant
// pops combinationally and the word is pushed to its output FIFO one cycle later.
//
// Optional feature: define RR_STATS_EN to build per-output push counters;
// without it cnt_0..3 are tied to 0.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   arb_en                1 = scheduling allowed
//   in_empty[3:0]         input FIFO empty flags
//   in_data_0..3          show-ahead head words of the input FIFOs
//   out_almost_full[3:0]  output FIFO almost-full flags
//   pop[3:0]              combinational one-hot/zero pop of the granted input
//   push[3:0]             registered one-hot/zero push into the output FIFO bank
//   out_data              registered word for the output FIFO bank
//   state[1:0]            00 IDLE, 01 ACTIVE, 10 HOLD, 11 DISABLED
//   stall_err             sticky: HOLD persisted for HOLD_TIMEOUT cycles
//   cnt_0..3              words pushed per output (RR_STATS_EN)
module rr_vc_scheduler #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned HOLD_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_en,
  input  logic [3:0]        in_empty,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_data_3,
  input  logic [3:0]        out_almost_full,
  output logic [3:0]        pop,
  output logic [3:0]        push,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        state,
  output logic              stall_err,
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1,
  output logic [CNT_W-1:0]  cnt_2,
  output logic [CNT_W-1:0]  cnt_3
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned HC_W = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACTIVE   = 2'b01,
    ST_HOLD     = 2'b10,
    ST_DISABLED = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data [NSRC];
  logic [1:0]        dest [NSRC];
  logic [3:0]        elig;
  logic [1:0]        ptr;
  logic [1:0]        idx;
  logic              gnt_valid;
  logic [1:0]        gnt_idx;
  logic [HC_W-1:0]   hold_cnt;

  assign data[0] = in_data_0;
  assign data[1] = in_data_1;
  assign data[2] = in_data_2;
  assign data[3] = in_data_3;
  assign state   = state_q;

  // Eligibility: enabled, source has a word, its destination can accept it.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      dest[i] = data[i][DATA_W-1 -: 2];
      elig[i] = !reset && arb_en && !in_empty[i] && !out_almost_full[dest[i]];
    end
  end

  // Rotating search starting at ptr; first eligible source wins and is popped.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    idx       = 2'd0;
    pop       = 4'b0000;
    for (int i = 0; i < NSRC; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_valid && elig[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
    if (gnt_valid) pop = 4'b0001 << gnt_idx;
  end

  // Next-state decode in priority order.
  always_comb begin
    state_d = ST_IDLE;
    if (!arb_en)          state_d = ST_DISABLED;
    else if (|elig)       state_d = ST_ACTIVE;
    else if (!(&in_empty)) state_d = ST_HOLD;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Output register, pointer advance and HOLD watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      push      <= 4'b0000;
      out_data  <= '0;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      stall_err <= 1'b0;
    end else begin
      push <= 4'b0000;
      if (gnt_valid) begin
        out_data <= data[gnt_idx];
        push     <= 4'b0001 << dest[gnt_idx];
        ptr      <= gnt_idx + 2'd1;
      end
      if (state_d == ST_HOLD) begin
        if (hold_cnt != HC_W'(HOLD_TIMEOUT)) hold_cnt <= hold_cnt + HC_W'(1);
        if (hold_cnt >= HC_W'(HOLD_TIMEOUT - 1)) stall_err <= 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

`ifdef RR_STATS_EN
  logic [CNT_W-1:0] cnt_q [NSRC];

  // Per-output push counters, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign cnt_0 = cnt_q[0];
  assign cnt_1 = cnt_q[1];
  assign cnt_2 = cnt_q[2];
  assign cnt_3 = cnt_q[3];
`else
  assign cnt_0 = '0;
  assign cnt_1 = '0;
  assign cnt_2 = '0;
  assign cnt_3 = '0;
`endif

endmodule

// File: tb/tb_rr_vc_scheduler.sv
// tb_rr_vc_scheduler: directed bench for rr_vc_scheduler. Input FIFOs are modelled
// as queues; each popped word is queued as the expected push of the next cycle.
module tb_rr_vc_scheduler;

  localparam int unsigned DW = 10;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          arb_en;
  logic [3:0]    in_empty;
  logic [DW-1:0] in_data_0, in_data_1, in_data_2, in_data_3;
  logic [3:0]    out_almost_full;
  logic [3:0]    pop, push;
  logic [DW-1:0] out_data;
  logic [1:0]    state;
  logic          stall_err;
  logic [CW-1:0] cnt_0, cnt_1, cnt_2, cnt_3;

  rr_vc_scheduler #(.DATA_W(DW), .HOLD_TIMEOUT(64), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .in_empty(in_empty),
    .in_data_0(in_data_0), .in_data_1(in_data_1),
    .in_data_2(in_data_2), .in_data_3(in_data_3),
    .out_almost_full(out_almost_full), .pop(pop), .push(push),
    .out_data(out_data), .state(state), .stall_err(stall_err),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] w;
  } sb_t;

  logic [DW-1:0] fq0[$], fq1[$], fq2[$], fq3[$];
  sb_t           sb[$];
  int            nvec = 0;
  int            nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fq_add(input int i, input logic [DW-1:0] w);
    case (i)
      0: fq0.push_back(w);
      1: fq1.push_back(w);
      2: fq2.push_back(w);
      default: fq3.push_back(w);
    endcase
  endtask

  task automatic fq_take(input int i, output logic [DW-1:0] w);
    w = '0;
    case (i)
      0: if (fq0.size() != 0) w = fq0.pop_front();
      1: if (fq1.size() != 0) w = fq1.pop_front();
      2: if (fq2.size() != 0) w = fq2.pop_front();
      default: if (fq3.size() != 0) w = fq3.pop_front();
    endcase
  endtask

  // Present queue heads as show-ahead FIFO outputs.
  task automatic apply_inputs();
    in_empty[0] = (fq0.size() == 0);
    in_empty[1] = (fq1.size() == 0);
    in_empty[2] = (fq2.size() == 0);
    in_empty[3] = (fq3.size() == 0);
    in_data_0 = in_empty[0] ? '0 : fq0[0];
    in_data_1 = in_empty[1] ? '0 : fq1[0];
    in_data_2 = in_empty[2] ? '0 : fq2[0];
    in_data_3 = in_empty[3] ? '0 : fq3[0];
  endtask

  // One cycle: check pop and the push owed from the previous cycle, then clock.
  task automatic step(input logic [3:0] exp_pop);
    sb_t           e;
    logic [DW-1:0] w;
    logic [3:0]    exp_push;
    apply_inputs();
    @(negedge clk);
    chk("pop", 32'(pop), 32'(exp_pop));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      exp_push = 4'b0000;
      if (e.v) exp_push = 4'b0001 << e.w[DW-1 -: 2];
      chk("push", 32'(push), 32'(exp_push));
      if (e.v) chk("out_data", 32'(out_data), 32'(e.w));
    end
    e = '0;
    for (int i = 0; i < 4; i++) begin
      if (exp_pop[i]) begin
        fq_take(i, w);
        e.v = 1'b1;
        e.w = w;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    arb_en = 1'b1;
    out_almost_full = 4'b0000;
    in_empty = 4'b0000;
    in_data_0 = 10'h000; in_data_1 = 10'h100; in_data_2 = 10'h200; in_data_3 = 10'h300;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pop_in_reset", 32'(pop), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    apply_inputs();
  endtask

  initial begin
    // Reset state with all inputs empty.
    do_reset();
    chk("rst_push", 32'(push), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_stall", 32'(stall_err), 32'h0);
    step(4'b0000);
    chk("idle_state", 32'(state), 32'h0);

    // Four inputs, 3 words each to dest 1: strict 0,1,2,3 rotation.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++)
        fq_add(i, {2'b01, 8'((i << 4) + k)});
    for (int k = 0; k < 12; k++) begin
      step(4'b0001 << (k % 4));
      if (k > 0) chk("active_state", 32'(state), 32'h1);
    end
    step(4'b0000);
    step(4'b0000);
    chk("drain_idle", 32'(state), 32'h0);

    // Move ptr to 2, then blocked input 2 is skipped in favour of input 0.
    fq_add(1, 10'h155);
    step(4'b0010);
    fq_add(2, 10'h3A5);
    fq_add(0, 10'h012);
    out_almost_full = 4'b1000;
    step(4'b0001);
    step(4'b0000);
    chk("blocked_hold", 32'(state), 32'h2);
    out_almost_full = 4'b0000;
    step(4'b0100);
    step(4'b0000);

    // Input 1 blocked long enough to trip the watchdog.
    fq_add(1, 10'h2C3);
    out_almost_full = 4'b0100;
    for (int j = 1; j <= 66; j++) begin
      step(4'b0000);
      if (j == 1 || j == 63 || j == 64 || j == 66) begin
        chk("hold_state", 32'(state), 32'h2);
        chk("stall_err", 32'(stall_err), 32'(j >= 64));
      end
    end
    out_almost_full = 4'b0000;
    step(4'b0010);
    step(4'b0000);
    chk("stall_sticky", 32'(stall_err), 32'h1);

    // Streaming with arb_en dropped; resume from ptr.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++)
        fq_add(i, {2'(i), 8'h50 + 8'(k)});
    step(4'b0100);
    step(4'b1000);
    arb_en = 1'b0;
    step(4'b0000);
    chk("disabled_state", 32'(state), 32'h3);
    step(4'b0000);
    chk("disabled_hold", 32'(state), 32'h3);
    arb_en = 1'b1;
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);
    step(4'b0000);
    step(4'b0000);

    // Counters: 5 words to dest 0, 2 to dest 3 after a fresh reset.
    do_reset();
    chk("rst_stall_clear", 32'(stall_err), 32'h0);
    for (int k = 0; k < 3; k++) fq_add(0, 10'h000 + 10'(k));
    for (int k = 0; k < 2; k++) fq_add(1, 10'h010 + 10'(k));
    for (int k = 0; k < 2; k++) fq_add(2, 10'h300 + 10'(k));
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b0001);
    step(4'b0000);
`ifdef RR_STATS_EN
    chk("cnt_0", 32'(cnt_0), 32'd5);
    chk("cnt_3", 32'(cnt_3), 32'd2);
`else
    chk("cnt_0", 32'(cnt_0), 32'd0);
    chk("cnt_3", 32'(cnt_3), 32'd0);
`endif
    chk("cnt_1", 32'(cnt_1), 32'd0);
    chk("cnt_2", 32'(cnt_2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
